regfile_sb: RTL
===============

# regfile_sb

Parametrised multi-read-port register file with an integrated pending-write scoreboard for the ARM pipeline. It serves all decode-stage operand reads in one cycle. Writeback data reaches same-cycle readers through a bypass. Each register carries a count of issued-but-not-retired writes, and that count drives the hazard unit. It replaces the single-write, two-read, negedge register file in the decode stage.

## Interface
- DATA_W, 32, register width in bits
- DEPTH, 16, number of registers (power of two, ≥2); AW = $clog2(DEPTH)
- NRD, 2, number of read ports (1..4)
- PEND_MAX, 3, max outstanding writes tracked per register; PW = $clog2(PEND_MAX+1)
- INIT_INDEX, 1, 1: register i resets to value i; 0: all registers reset to 0

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset rst, asynchronous, active-high
- rd_addr  in  NRD*AW  packed read addresses; port k at [k*AW +: AW]
- rd_data  out  NRD*DATA_W  packed read data, combinational
- rd_busy  out  NRD  port k source has a pending write not satisfied this cycle
- wr_en  in  1  writeback strobe
- wr_addr  in  AW  writeback register
- wr_data  in  DATA_W  writeback data
- iss_en  in  1  an instruction writing iss_addr is issued this cycle
- iss_addr  in  AW  destination of the issued instruction
- flush  in  1  synchronous: clear all pending counters
- busy_vec  out  DEPTH  bit i = (cnt[i] != 0), registered state
- sb_err  out  1  sticky overflow flag

## Operation
- Storage: mem[DEPTH] of DATA_W. cnt[DEPTH] of PW bits.
- Reset (async): mem[i] = INIT_INDEX ? i (zero-extended/truncated to DATA_W) : 0. cnt = 0. sb_err = 0. Outputs after reset: busy_vec = 0, rd_busy = 0, rd_data = reset contents.
- Write: on posedge, if wr_en, mem[wr_addr] <= wr_data. Writes to every index are allowed, including 0.
- Read port k: rd_data_k = (wr_en && wr_addr == rd_addr_k) ? wr_data : mem[rd_addr_k]. Bypass applies to all ports independently.
- rd_busy_k = cnt[a] > ((wr_en && wr_addr == a) ? 1 : 0), where a = rd_addr_k. A same-cycle iss_en does not affect rd_busy, because the issuing instruction is younger.
- Counter update per register r, on posedge:
  - inc = iss_en && iss_addr == r && !flush
  - dec = wr_en && wr_addr == r && cnt[r] != 0
  - inc && dec: unchanged. inc only: +1. dec only: −1.
  - inc when cnt[r] == PEND_MAX: the increment is dropped and sb_err <= 1.
  - wr_en to a register with cnt 0: data is written, counter stays 0, no error.
- flush: all cnt <= 0 on that edge, regardless of inc/dec. A same-cycle wr_en still writes mem. sb_err is unaffected; only rst clears it.

## Timing
- Read latency 0 cycles (combinational from rd_addr, wr_*, and state).
- Write to read visibility: same cycle via bypass, and from mem from the next cycle onward.
- Counter change is visible on busy_vec/rd_busy one cycle after the iss_en/wr_en edge, with the rd_busy bypass term as specified above.
- rst asserted mid-operation: state resets immediately. Writes and issues in progress are lost.
- No combinational path from iss_en or flush to any output.

## Structure
- Package arm_rf_pkg holds the AW/PW helper functions ($clog2 wrappers) and the reset-mode constants for INIT_INDEX.
- Sub-module sb_counter: one per register (generate loop). Inputs inc, dec, clr. Outputs cnt, nonzero, ovf. Saturates at PEND_MAX. Async rst.
- Top level contains the mem array, read muxes with bypass, the rd_busy compare, and the sb_err OR-reduction of ovf.

## Test plan
- Reset with INIT_INDEX=1, DEPTH=16: read r0..r15 on both ports -> rd_data = 0..15; busy_vec = 0; sb_err = 0.
- Write r5 = 0xDEADBEEF while port0 reads r5 -> rd_data0 = 0xDEADBEEF in the same cycle; next cycle with wr_en=0 -> still 0xDEADBEEF.
- Issue r3 twice, then wr r3 once -> busy_vec[3] = 1 after each step. On the second write cycle, with port1 reading r3 -> rd_busy1 = 0; the cycle after -> busy_vec[3] = 0.
- Simultaneous iss_en and wr_en to r7 with cnt[7] = 1 -> cnt stays 1. Then 3 more issues with PEND_MAX = 3 -> the third is dropped and sb_err = 1 (sticky).
- flush with cnt[2] = 2 and same-cycle wr r2 = 0x55 -> next cycle busy_vec = 0 and mem[2] = 0x55; iss_en during flush is ignored; sb_err holds its value.
- Async rst asserted between clock edges after writes -> contents return to index values immediately; NRD = 4 build passes all four ports.

Source files
------------

// File: rtl/arm_rf_pkg.sv
// Shared sizing helpers and reset-mode constants for the decode-stage register file.
package arm_rf_pkg;

    localparam int RST_MODE_ZERO  = 0;
    localparam int RST_MODE_INDEX = 1;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int pend_w(input int pend_max);
        return (pend_max > 0) ? $clog2(pend_max + 1) : 1;
    endfunction

endpackage

// File: rtl/sb_counter.sv
// Per-register pending-write counter: counts issued-but-not-retired writes, saturating at PEND_MAX.
module sb_counter #(
    parameter int PEND_MAX = 3,
    parameter int PW       = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    input  logic          clr,
    output logic [PW-1:0] cnt,
    output logic          nonzero,
    output logic          ovf
);

    localparam logic [PW-1:0] CNT_MAX = PW'(PEND_MAX);

    logic dec_eff;
    logic at_max;

    assign nonzero = (cnt != '0);
    assign at_max  = (cnt == CNT_MAX);
    assign dec_eff = dec && nonzero;

    // A simultaneous retire frees a slot, so only an unmatched issue at the limit is lost.
    assign ovf = inc && !dec_eff && at_max && !clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !dec_eff && !at_max) begin
            cnt <= cnt + PW'(1);
        end else if (dec_eff && !inc) begin
            cnt <= cnt - PW'(1);
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with writeback bypass and a per-register pending-write scoreboard.
module regfile_sb
    import arm_rf_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 16,
    parameter int NRD        = 2,
    parameter int PEND_MAX   = 3,
    parameter int INIT_INDEX = 1,
    localparam int AW        = addr_w(DEPTH),
    localparam int PW        = pend_w(PEND_MAX)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  iss_en,
    input  logic [AW-1:0]         iss_addr,
    input  logic                  flush,
    output logic [DEPTH-1:0]      busy_vec,
    output logic                  sb_err
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     cnt [DEPTH];
    logic [DEPTH-1:0]  ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= (INIT_INDEX == RST_MODE_INDEX) ? DATA_W'(i) : '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Issue and writeback are decoded per register; flush gates issue so it can never overflow.
    for (genvar r = 0; r < DEPTH; r++) begin : g_sb
        logic inc;
        logic dec;

        assign inc = iss_en && (iss_addr == AW'(r)) && !flush;
        assign dec = wr_en && (wr_addr == AW'(r));

        sb_counter #(
            .PEND_MAX (PEND_MAX),
            .PW       (PW)
        ) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .inc     (inc),
            .dec     (dec),
            .clr     (flush),
            .cnt     (cnt[r]),
            .nonzero (busy_vec[r]),
            .ovf     (ovf[r])
        );
    end

    // A writeback landing this cycle both forwards its data and retires one pending write.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] a;
        logic          hit;

        assign a   = rd_addr[k*AW +: AW];
        assign hit = wr_en && (wr_addr == a);

        assign rd_data[k*DATA_W +: DATA_W] = hit ? wr_data : mem[a];
        assign rd_busy[k] = cnt[a] > (hit ? PW'(1) : PW'(0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_err <= 1'b0;
        end else if (|ovf) begin
            sb_err <= 1'b1;
        end
    end

endmodule
